// File: rtl/mem_port_arbiter_if.sv
// Memory port arbiter signal bundle: fetch channel, load/store channel,
// flush, and the shared bus. The arbiter uses the master view; the
// surrounding pipeline/bus model uses the slave view.
interface mem_port_arbiter_if;
  logic        flush_i;

  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        if_err_o;

  logic        lsu_req_i;
  logic [31:0] lsu_addr_i;
  logic        lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_gnt_o;
  logic        lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        lsu_err_o;

  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  modport master (
    input  flush_i,
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  lsu_req_i, lsu_addr_i, lsu_we_i, lsu_be_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );

  modport slave (
    output flush_i,
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output lsu_req_i, lsu_addr_i, lsu_we_i, lsu_be_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one bus port between instruction fetch and
// load/store. LSU has fixed priority; IF wins after STARVE_LIMIT lost IDLE
// cycles. One transaction outstanding, response routed to its owner, fetch
// responses discarded after a flush.
// Optional: define MEM_ARB_TIMEOUT_EN to force an error response after
// TIMEOUT_CYCLES WAIT cycles without a bus response.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_IF  = 2'd1,
    S_WAIT_LSU = 2'd2
  } state_t;

  localparam logic [15:0] LP_STARVE = 16'(STARVE_LIMIT);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_starve_cnt, w_starve_nxt;
  logic        r_drop, w_drop_nxt;

  logic        w_run;
  logic        w_waiting;
  logic        w_if_starved;
  logic        w_sel_lsu;
  logic        w_sel_if;
  logic        w_if_gnt;
  logic        w_lsu_gnt;
  logic        w_resp;
  logic        w_timeout;
  logic [31:0] w_rdata;
  logic        w_err;

  // reset is active-low; outputs are forced to 0 while it is held
  assign w_run     = reset;
  assign w_waiting = (r_state == S_WAIT_IF) || (r_state == S_WAIT_LSU);

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] r_wait_cnt;

  // count WAIT cycles of the current transaction; cleared outside WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  r_wait_cnt <= '0;
    else if (w_waiting && !w_resp) r_wait_cnt <= r_wait_cnt + 16'd1;
    else                         r_wait_cnt <= '0;
  end

  assign w_timeout = w_waiting && (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // state, starvation counter and fetch-drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_drop       <= w_drop_nxt;
    end
  end

  // arbitration, bus muxing, response routing and next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_drop_nxt   = r_drop;
    w_if_starved = 1'b0;
    w_sel_lsu    = 1'b0;
    w_sel_if     = 1'b0;
    w_if_gnt     = 1'b0;
    w_lsu_gnt    = 1'b0;
    w_resp       = 1'b0;
    w_rdata      = '0;
    w_err        = 1'b0;

    bus.mem_req_o    = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_we_o     = 1'b0;
    bus.mem_be_o     = '0;
    bus.mem_wdata_o  = '0;
    bus.if_gnt_o     = 1'b0;
    bus.if_rvalid_o  = 1'b0;
    bus.if_rdata_o   = '0;
    bus.if_err_o     = 1'b0;
    bus.lsu_gnt_o    = 1'b0;
    bus.lsu_rvalid_o = 1'b0;
    bus.lsu_rdata_o  = '0;
    bus.lsu_err_o    = 1'b0;

    if (w_run && (r_state == S_IDLE)) begin
      w_if_starved = (STARVE_LIMIT != 0) && (r_starve_cnt == LP_STARVE) && bus.if_req_i;
      w_sel_lsu    = bus.lsu_req_i && !w_if_starved;
      w_sel_if     = bus.if_req_i && !w_sel_lsu;

      if (w_sel_lsu) begin
        bus.mem_req_o   = 1'b1;
        bus.mem_addr_o  = bus.lsu_addr_i;
        bus.mem_we_o    = bus.lsu_we_i;
        bus.mem_be_o    = bus.lsu_be_i;
        bus.mem_wdata_o = bus.lsu_wdata_i;
      end else if (w_sel_if) begin
        bus.mem_req_o   = 1'b1;
        bus.mem_addr_o  = bus.if_addr_i;
        bus.mem_be_o    = 4'hF;
      end

      w_lsu_gnt     = w_sel_lsu && bus.mem_gnt_i;
      w_if_gnt      = w_sel_if && bus.mem_gnt_i;
      bus.lsu_gnt_o = w_lsu_gnt;
      bus.if_gnt_o  = w_if_gnt;

      if (w_lsu_gnt)     w_state_nxt = S_WAIT_LSU;
      else if (w_if_gnt) w_state_nxt = S_WAIT_IF;

      // saturating count of IDLE cycles in which IF asked and lost
      if (w_if_gnt)
        w_starve_nxt = '0;
      else if (bus.if_req_i && (r_starve_cnt != LP_STARVE))
        w_starve_nxt = r_starve_cnt + 16'd1;

      if (bus.flush_i && w_if_gnt) w_drop_nxt = 1'b1;
    end

    if (w_run && w_waiting) begin
      w_resp = bus.mem_rvalid_i || w_timeout;
      // a timeout without a real response reports an error with zero data
      w_rdata = bus.mem_rvalid_i ? bus.mem_rdata_i : '0;
      w_err   = bus.mem_rvalid_i ? bus.mem_err_i : 1'b1;

      if (r_state == S_WAIT_LSU) begin
        if (w_resp) begin
          bus.lsu_rvalid_o = 1'b1;
          bus.lsu_rdata_o  = w_rdata;
          bus.lsu_err_o    = w_err;
          w_state_nxt      = S_IDLE;
        end
      end else begin
        // a flush in the response cycle itself also discards the fetch
        if (w_resp) begin
          if (!r_drop && !bus.flush_i) begin
            bus.if_rvalid_o = 1'b1;
            bus.if_rdata_o  = w_rdata;
            bus.if_err_o    = w_err;
          end
          w_drop_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (bus.flush_i) begin
          w_drop_nxt = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: arbitration, starvation override,
// flush drop, store fields, bus backpressure, reset mid-transaction, and
// (with MEM_ARB_TIMEOUT_EN) the forced timeout response.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if bus_if ();

  mem_port_arbiter #(
    .STARVE_LIMIT   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus_if.flush_i      = 1'b0;
    bus_if.if_req_i     = 1'b1;
    bus_if.if_addr_i    = 32'h100;
    bus_if.lsu_req_i    = 1'b1;
    bus_if.lsu_addr_i   = 32'h2000;
    bus_if.lsu_we_i     = 1'b0;
    bus_if.lsu_be_i     = 4'hF;
    bus_if.lsu_wdata_i  = '0;
    bus_if.mem_gnt_i    = 1'b1;
    bus_if.mem_rvalid_i = 1'b0;
    bus_if.mem_rdata_i  = '0;
    bus_if.mem_err_i    = 1'b0;

    // reset: outputs held at 0 even with requests present
    @(negedge clk); #1;
    chk("rst_mem_req", 32'(bus_if.mem_req_o), 0);
    chk("rst_lsu_gnt", 32'(bus_if.lsu_gnt_o), 0);
    chk("rst_if_gnt",  32'(bus_if.if_gnt_o), 0);
    chk("rst_mem_addr", bus_if.mem_addr_o, 0);

    // 1: simultaneous requests, LSU wins
    @(negedge clk); reset = 1'b1; #1;
    chk("t1_lsu_gnt",  32'(bus_if.lsu_gnt_o), 1);
    chk("t1_if_gnt",   32'(bus_if.if_gnt_o), 0);
    chk("t1_mem_addr", bus_if.mem_addr_o, 32'h2000);
    chk("t1_mem_req",  32'(bus_if.mem_req_o), 1);
    @(negedge clk);
    bus_if.lsu_req_i = 1'b0; bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rdata_i = 32'hCAFE0001; #1;
    chk("t1_wait_req",    32'(bus_if.mem_req_o), 0);
    chk("t1_wait_ifgnt",  32'(bus_if.if_gnt_o), 0);
    chk("t1_lsu_rvalid",  32'(bus_if.lsu_rvalid_o), 1);
    chk("t1_lsu_rdata",   bus_if.lsu_rdata_o, 32'hCAFE0001);
    chk("t1_if_rvalid",   32'(bus_if.if_rvalid_o), 0);
    @(negedge clk); bus_if.mem_rvalid_i = 1'b0; #1;
    chk("t1_if_gnt2",  32'(bus_if.if_gnt_o), 1);
    chk("t1_if_addr",  bus_if.mem_addr_o, 32'h100);
    chk("t1_if_be",    32'(bus_if.mem_be_o), 32'hF);
    chk("t1_if_we",    32'(bus_if.mem_we_o), 0);
    @(negedge clk);
    bus_if.if_req_i = 1'b0; bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rdata_i = 32'h11112222; #1;
    chk("t1_if_rvalid2", 32'(bus_if.if_rvalid_o), 1);
    chk("t1_if_rdata",   bus_if.if_rdata_o, 32'h11112222);
    chk("t1_lsu_rvalid2", 32'(bus_if.lsu_rvalid_o), 0);
    @(negedge clk); bus_if.mem_rvalid_i = 1'b0;

    // 2: starvation override after 4 lost IDLE cycles
    bus_if.lsu_req_i = 1'b1; bus_if.lsu_addr_i = 32'h2004;
    bus_if.if_req_i  = 1'b1; bus_if.if_addr_i  = 32'h104; #1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_lsu_gnt", 32'(bus_if.lsu_gnt_o), 1);
      chk("t2_if_lose", 32'(bus_if.if_gnt_o), 0);
      @(negedge clk); bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rdata_i = 32'(i); #1;
      chk("t2_lsu_rvalid", 32'(bus_if.lsu_rvalid_o), 1);
      @(negedge clk); bus_if.mem_rvalid_i = 1'b0; #1;
    end
    chk("t2_if_win",   32'(bus_if.if_gnt_o), 1);
    chk("t2_lsu_lose", 32'(bus_if.lsu_gnt_o), 0);
    chk("t2_if_addr",  bus_if.mem_addr_o, 32'h104);
    @(negedge clk); bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rdata_i = 32'hABCD; #1;
    chk("t2_if_rvalid", 32'(bus_if.if_rvalid_o), 1);
    @(negedge clk); bus_if.mem_rvalid_i = 1'b0; #1;
    chk("t2_cnt_cleared", 32'(bus_if.lsu_gnt_o), 1);
    @(negedge clk);
    bus_if.lsu_req_i = 1'b0; bus_if.if_req_i = 1'b0; bus_if.mem_rvalid_i = 1'b1;
    @(negedge clk); bus_if.mem_rvalid_i = 1'b0;

    // 3: flush one cycle after fetch grant drops the response
    bus_if.if_req_i = 1'b1; bus_if.if_addr_i = 32'h100; #1;
    chk("t3_if_gnt", 32'(bus_if.if_gnt_o), 1);
    @(negedge clk); bus_if.if_req_i = 1'b0; bus_if.flush_i = 1'b1; #1;
    chk("t3_flush_rvalid", 32'(bus_if.if_rvalid_o), 0);
    @(negedge clk);
    bus_if.flush_i = 1'b0; bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rdata_i = 32'hDEAD; #1;
    chk("t3_drop_rvalid", 32'(bus_if.if_rvalid_o), 0);
    chk("t3_drop_rdata",  bus_if.if_rdata_o, 0);
    @(negedge clk);
    bus_if.mem_rvalid_i = 1'b0; bus_if.if_req_i = 1'b1; bus_if.if_addr_i = 32'h108; #1;
    chk("t3_if_gnt2", 32'(bus_if.if_gnt_o), 1);
    @(negedge clk);
    bus_if.if_req_i = 1'b0; bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rdata_i = 32'h5555; #1;
    chk("t3_after_drop_rvalid", 32'(bus_if.if_rvalid_o), 1);
    chk("t3_after_drop_rdata",  bus_if.if_rdata_o, 32'h5555);
    // flush on the grant cycle itself
    @(negedge clk);
    bus_if.mem_rvalid_i = 1'b0; bus_if.if_req_i = 1'b1; bus_if.flush_i = 1'b1; #1;
    chk("t3_gntflush_gnt", 32'(bus_if.if_gnt_o), 1);
    @(negedge clk);
    bus_if.flush_i = 1'b0; bus_if.if_req_i = 1'b0; bus_if.mem_rvalid_i = 1'b1; #1;
    chk("t3_gntflush_rvalid", 32'(bus_if.if_rvalid_o), 0);
    // flush does not touch LSU
    @(negedge clk);
    bus_if.mem_rvalid_i = 1'b0; bus_if.lsu_req_i = 1'b1; bus_if.lsu_addr_i = 32'h2010; #1;
    chk("t3_lsu_gnt", 32'(bus_if.lsu_gnt_o), 1);
    @(negedge clk);
    bus_if.lsu_req_i = 1'b0; bus_if.flush_i = 1'b1;
    bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rdata_i = 32'h77; #1;
    chk("t3_lsu_rvalid", 32'(bus_if.lsu_rvalid_o), 1);
    chk("t3_lsu_rdata",  bus_if.lsu_rdata_o, 32'h77);
    @(negedge clk); bus_if.flush_i = 1'b0; bus_if.mem_rvalid_i = 1'b0;

    // 4: store fields and error response
    bus_if.lsu_req_i = 1'b1; bus_if.lsu_addr_i = 32'h3000; bus_if.lsu_we_i = 1'b1;
    bus_if.lsu_be_i  = 4'b0011; bus_if.lsu_wdata_i = 32'h1234; #1;
    chk("t4_we",    32'(bus_if.mem_we_o), 1);
    chk("t4_be",    32'(bus_if.mem_be_o), 32'h3);
    chk("t4_wdata", bus_if.mem_wdata_o, 32'h1234);
    chk("t4_gnt",   32'(bus_if.lsu_gnt_o), 1);
    @(negedge clk);
    bus_if.lsu_req_i = 1'b0; bus_if.lsu_we_i = 1'b0; bus_if.lsu_be_i = 4'hF; bus_if.lsu_wdata_i = '0;
    bus_if.mem_rvalid_i = 1'b1; bus_if.mem_err_i = 1'b1; bus_if.mem_rdata_i = '0; #1;
    chk("t4_rvalid", 32'(bus_if.lsu_rvalid_o), 1);
    chk("t4_err",    32'(bus_if.lsu_err_o), 1);
    @(negedge clk); bus_if.mem_rvalid_i = 1'b0; bus_if.mem_err_i = 1'b0;

    // 5: bus withholds grant for 3 cycles
    bus_if.mem_gnt_i = 1'b0; bus_if.lsu_req_i = 1'b1; bus_if.lsu_addr_i = 32'h4000;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_req",  32'(bus_if.mem_req_o), 1);
      chk("t5_addr", bus_if.mem_addr_o, 32'h4000);
      chk("t5_nognt", 32'(bus_if.lsu_gnt_o), 0);
      @(negedge clk);
    end
    bus_if.mem_gnt_i = 1'b1; #1;
    chk("t5_gnt", 32'(bus_if.lsu_gnt_o), 1);
    @(negedge clk); bus_if.lsu_req_i = 1'b0; bus_if.mem_rvalid_i = 1'b1;
    @(negedge clk); bus_if.mem_rdata_i = 32'h99; #1;
    // stray response while IDLE is ignored
    chk("idle_lsu_rvalid", 32'(bus_if.lsu_rvalid_o), 0);
    chk("idle_if_rvalid",  32'(bus_if.if_rvalid_o), 0);
    chk("idle_lsu_rdata",  bus_if.lsu_rdata_o, 0);
    chk("idle_mem_req",    32'(bus_if.mem_req_o), 0);
    @(negedge clk); bus_if.mem_rvalid_i = 1'b0;

    // reset asserted while in WAIT_LSU
    bus_if.lsu_req_i = 1'b1; bus_if.lsu_addr_i = 32'h5000; #1;
    chk("rw_gnt", 32'(bus_if.lsu_gnt_o), 1);
    @(negedge clk); #1;
    chk("rw_wait_req", 32'(bus_if.mem_req_o), 0);
    reset = 1'b0; bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rdata_i = 32'h42; #1;
    chk("rw_rvalid", 32'(bus_if.lsu_rvalid_o), 0);
    chk("rw_rdata",  bus_if.lsu_rdata_o, 0);
    chk("rw_req",    32'(bus_if.mem_req_o), 0);
    chk("rw_lsugnt", 32'(bus_if.lsu_gnt_o), 0);
    @(negedge clk); reset = 1'b1; bus_if.lsu_req_i = 1'b0; #1;
    chk("rw_idle_rvalid", 32'(bus_if.lsu_rvalid_o), 0);
    @(negedge clk); bus_if.mem_rvalid_i = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // 6: no bus response, forced error on the 8th WAIT cycle
    bus_if.if_req_i = 1'b1; bus_if.if_addr_i = 32'h600; bus_if.mem_rdata_i = 32'hFFFF; #1;
    chk("t6_gnt", 32'(bus_if.if_gnt_o), 1);
    @(negedge clk); bus_if.if_req_i = 1'b0;
    for (int k = 1; k < 8; k++) begin
      #1;
      chk("t6_pre_rvalid", 32'(bus_if.if_rvalid_o), 0);
      @(negedge clk);
    end
    #1;
    chk("t6_to_rvalid", 32'(bus_if.if_rvalid_o), 1);
    chk("t6_to_err",    32'(bus_if.if_err_o), 1);
    chk("t6_to_rdata",  bus_if.if_rdata_o, 0);
    @(negedge clk); bus_if.mem_rvalid_i = 1'b1; bus_if.mem_rdata_i = 32'h123; #1;
    chk("t6_stray_rvalid", 32'(bus_if.if_rvalid_o), 0);
    chk("t6_idle_req",     32'(bus_if.mem_req_o), 0);
    @(negedge clk); bus_if.mem_rvalid_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
